// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Supervises the HDMI 720p PLL from the 50 MHz board clock: pulses the PLL
//   reset, qualifies lock stability, and releases the synchronous downstream
//   reset only while the PLL is locked.
//   Optional feature macro: PLL_SUP_RETRY_LIMIT_EN (retry limit -> FAIL state).
module pll_lock_supervisor #(
    parameter int unsigned RESET_CYCLES        = 50,
    parameter int unsigned LOCK_STABLE_CYCLES  = 5000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic [7:0] relock_count,
    output logic       pll_fail,
    output logic [1:0] state
);

    localparam logic [1:0] ST_PLL_RESET = 2'b00;
    localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
    localparam logic [1:0] ST_RUN       = 2'b10;
    localparam logic [1:0] ST_FAIL      = 2'b11;

    localparam int unsigned MAX_AB = (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                     RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD = (LOCK_TIMEOUT_CYCLES > MAX_RETRIES) ?
                                     LOCK_TIMEOUT_CYCLES : MAX_RETRIES;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync1_q;
    logic             lock_s_q;
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] stable_q,   stable_d;
    logic [7:0]       relock_q,   relock_d;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_q,   sys_rst_d;
    logic             locked_q,    locked_d;

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(MAX_RETRIES - 1);
    logic             retry_q,    retry_unused;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             pll_fail_q,  pll_fail_d;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock signal
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state, counter and output decode; outputs are decoded from the
    // next state so the registered outputs always agree with state_q
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        relock_d = relock_q;
`ifdef PLL_SUP_RETRY_LIMIT_EN
        retry_cnt_d = retry_cnt_q;
`endif
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                cnt_d    = cnt_q + CNT_ONE;
                stable_d = lock_s_q ? (stable_q + CNT_ONE) : '0;
                // Stable-lock release takes priority over a coincident timeout
                if (lock_s_q && (stable_q == STABLE_LAST)) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    stable_d = '0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    retry_cnt_d = '0;
`endif
                end else if (cnt_q == TO_LAST) begin
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = ST_PLL_RESET;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    if (retry_cnt_q != '1) begin
                        retry_cnt_d = retry_cnt_q + CNT_ONE;
                    end
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_PLL_RESET;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
`ifdef PLL_SUP_RETRY_LIMIT_EN
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
`endif
            default: begin
                state_d  = ST_PLL_RESET;
                cnt_d    = '0;
                stable_d = '0;
            end
        endcase

        pll_reset_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAIL);
        sys_rst_d   = (state_d != ST_RUN);
        locked_d    = (state_d == ST_RUN);
`ifdef PLL_SUP_RETRY_LIMIT_EN
        pll_fail_d  = (state_d == ST_FAIL);
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            stable_q    <= '0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            relock_q    <= relock_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            locked_q    <= locked_d;
        end
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    // Retry counter and failure flag
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_q <= '0;
            pll_fail_q  <= 1'b0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            pll_fail_q  <= pll_fail_d;
        end
    end

    assign pll_fail = pll_fail_q;
`else
    assign pll_fail = 1'b0;
`endif

    assign pll_reset    = pll_reset_q;
    assign sys_rst      = sys_rst_q;
    assign locked       = locked_q;
    assign relock_count = relock_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with small sim parameters
//   (RESET=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2). Honors PLL_SUP_RETRY_LIMIT_EN.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       locked;
    logic [7:0] relock_count;
    logic       pll_fail;
    logic [1:0] state;

    int n_checks;
    int n_fail;

    pll_lock_supervisor #(
        .RESET_CYCLES       (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .sys_rst     (sys_rst),
        .locked      (locked),
        .relock_count(relock_count),
        .pll_fail    (pll_fail),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       pr;
        logic       sr;
        logic       lk;
        logic [7:0] rc;
        logic       pf;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, input logic l, input logic pr,
                                input logic sr, input logic lk, input logic [7:0] rc,
                                input logic pf, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.lock = l; v.pr = pr; v.sr = sr;
        v.lk = lk; v.rc = rc; v.pf = pf; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l);
        rst      = r;
        pll_lock = l;
        @(posedge clk);
        #1;
    endtask

    // Step with lock high until RUN, bounded
    task automatic wait_run(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            step(1'b0, 1'b1);
            if (state == 2'b10) break;
        end
        chk(name, 0, 32'(state), 32'(2'b10));
    endtask

    // One-cycle lock drop from RUN, confirm the drop is seen, then re-lock
    task automatic drop_and_relock(input int idx);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("drop_state", idx, 32'(state), 32'(2'b00));
        wait_run("relock_wait", 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        pll_lock = 1'b1;

        // Power-up with lock constantly high
        for (int i = 0; i < 3; i++)   tbl[i] = mk(1, 1, 1, 1, 0, 8'd0, 0, 2'b00);
        for (int i = 3; i < 6; i++)   tbl[i] = mk(0, 1, 1, 1, 0, 8'd0, 0, 2'b00);
        for (int i = 6; i < 14; i++)  tbl[i] = mk(0, 1, 0, 1, 0, 8'd0, 0, 2'b01);
        for (int i = 14; i < 17; i++) tbl[i] = mk(0, 1, 0, 0, 1, 8'd0, 0, 2'b10);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].lock);
            chk("t1_pll_reset", i, 32'(pll_reset),    32'(tbl[i].pr));
            chk("t1_sys_rst",   i, 32'(sys_rst),      32'(tbl[i].sr));
            chk("t1_locked",    i, 32'(locked),       32'(tbl[i].lk));
            chk("t1_relock",    i, 32'(relock_count), 32'(tbl[i].rc));
            chk("t1_pll_fail",  i, 32'(pll_fail),     32'(tbl[i].pf));
            chk("t1_state",     i, 32'(state),        32'(tbl[i].st));
        end

        // Single-cycle lock drop in RUN
        step(1'b0, 1'b0);
        chk("t2_still_run", 0, 32'(sys_rst), 32'd0);
        step(1'b0, 1'b1);
        chk("t2_still_run", 1, 32'(sys_rst), 32'd0);
        step(1'b0, 1'b1);
        chk("t2_sys_rst",   0, 32'(sys_rst),      32'd1);
        chk("t2_locked",    0, 32'(locked),       32'd0);
        chk("t2_pll_reset", 0, 32'(pll_reset),    32'd1);
        chk("t2_relock",    0, 32'(relock_count), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("t2_pll_reset", i, 32'(pll_reset), 32'd1);
        end
        step(1'b0, 1'b1);
        chk("t2_pll_reset_low", 0, 32'(pll_reset), 32'd0);
        chk("t2_wait_state",    0, 32'(state),     32'(2'b01));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            chk("t2_hold_rst", i, 32'(sys_rst), 32'd1);
        end
        step(1'b0, 1'b1);
        chk("t2_rerelease", 0, 32'(sys_rst), 32'd0);
        chk("t2_relocked",  0, 32'(locked),  32'd1);
        chk("t2_relock",    1, 32'(relock_count), 32'd1);

        // Broken stable run in WAIT_LOCK: 7 high, 1 low, 8 high
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("t3_wait_entry", 0, 32'(state), 32'(2'b01));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i == 7) ? 1'b0 : 1'b1);
            chk("t3_hold", i, 32'(state), 32'(2'b01));
        end
        step(1'b0, 1'b1);
        chk("t3_hold", 16, 32'(state), 32'(2'b01));
        step(1'b0, 1'b1);
        chk("t3_release", 0, 32'(state),   32'(2'b10));
        chk("t3_release", 1, 32'(sys_rst), 32'd0);

        // Reset while in RUN with relock_count=3
        for (int i = 0; i < 3; i++) drop_and_relock(i);
        chk("t6_relock_pre", 0, 32'(relock_count), 32'd3);
        step(1'b1, 1'b1);
        chk("t6_state",     0, 32'(state),        32'(2'b00));
        chk("t6_sys_rst",   0, 32'(sys_rst),      32'd1);
        chk("t6_pll_reset", 0, 32'(pll_reset),    32'd1);
        chk("t6_relock",    0, 32'(relock_count), 32'd0);
        chk("t6_locked",    0, 32'(locked),       32'd0);

        // relock_count saturation at 255
        wait_run("sat_first_run", 40);
        for (int i = 0; i < 255; i++) drop_and_relock(i);
        chk("sat_255", 0, 32'(relock_count), 32'd255);
        drop_and_relock(255);
        chk("sat_hold", 0, 32'(relock_count), 32'd255);

`ifdef PLL_SUP_RETRY_LIMIT_EN
        // Lock never arrives: two timeouts then FAIL
        step(1'b1, 1'b0);
        for (int k = 0; k < 71; k++) begin
            step(1'b0, 1'b0);
            if (k == 34) chk("t5_state_wait", k, 32'(state), 32'(2'b01));
            if (k == 35) chk("t5_state_retry", k, 32'(state), 32'(2'b00));
            if (k == 70) chk("t5_state_wait", k, 32'(state), 32'(2'b01));
            chk("t5_no_fail", k, 32'(pll_fail), 32'd0);
        end
        step(1'b0, 1'b0);
        chk("t5_fail_state", 0, 32'(state),     32'(2'b11));
        chk("t5_pll_fail",   0, 32'(pll_fail),  32'd1);
        chk("t5_pll_reset",  0, 32'(pll_reset), 32'd1);
        chk("t5_sys_rst",    0, 32'(sys_rst),   32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            chk("t5_fail_hold", i, 32'(state), 32'(2'b11));
        end
        step(1'b1, 1'b1);
        chk("t5_rst_state", 0, 32'(state),    32'(2'b00));
        chk("t5_rst_fail",  0, 32'(pll_fail), 32'd0);
`else
        // Lock never arrives: endless 4-on / 32-off PLL reset pulses
        step(1'b1, 1'b0);
        for (int k = 0; k < 108; k++) begin
            step(1'b0, 1'b0);
            chk("t4_pll_reset", k, 32'(pll_reset), 32'(((k + 1) % 36) < 4));
            chk("t4_sys_rst",   k, 32'(sys_rst),   32'd1);
            chk("t4_pll_fail",  k, 32'(pll_fail),  32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
